// File: rtl/cacheline_arbiter_if.sv
// Bus bundle between the two cache miss paths, the arbiter and the downstream
// cacheline memory port.
//   slave  : arbiter view (takes cache requests and memory responses, drives
//            cache responses and memory strobes)
//   master : environment view (caches plus memory model), the mirror image
// Signals:
//   i_read/i_addr                          I-cache fill request
//   i_rdata/i_resp                         I-cache fill data / completion
//   d_read/d_write/d_addr/d_wdata          D-cache fill or writeback request
//   d_rdata/d_resp                         D-cache fill data / completion
//   mem_read/mem_write/mem_addr/mem_wdata  downstream request
//   mem_rdata/mem_resp                     downstream data / completion pulse
interface cacheline_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// Arbitrates one cacheline memory port between the I-cache (read only) and the
// D-cache (read/write). The winning request is latched, a single transaction is
// held on the memory port until mem_resp, the response is routed to its owner,
// and a one-cycle DONE turnaround precedes the next arbitration.
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   bus          cacheline_arbiter_if.slave (cache and memory signals)
//   err_timeout  sticky flag: a transaction waited TIMEOUT cycles for mem_resp
// Parameters: LINE_W line width, ADDR_W address width, TIMEOUT wait limit.
// Build option: define ARB_ROUND_ROBIN_EN to resolve ties in favour of the
// requester not granted last; otherwise the D-cache always wins ties.
module cacheline_arbiter #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  cacheline_arbiter_if.slave    bus,
  output logic                  err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t            state;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              d_req;
  logic              grant_d;

  assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = D-cache held the most recent grant; reset value makes I win the first tie
  logic last_d;

  assign grant_d = d_req & (~bus.i_read | ~last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b1;
    end else if (state == IDLE) begin
      if (grant_d) begin
        last_d <= 1'b1;
      end else if (bus.i_read) begin
        last_d <= 1'b0;
      end
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            // write takes precedence when d_read and d_write are both high
            state       <= SERVE_D;
            mem_read_q  <= ~bus.d_write;
            mem_write_q <= bus.d_write;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            wait_cnt    <= '0;
          end else if (bus.i_read) begin
            state       <= SERVE_I;
            mem_read_q  <= 1'b1;
            mem_write_q <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            wait_cnt    <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          // the edge that brings the count to TIMEOUT raises the sticky flag
          if (wait_cnt == CNT_MAX - 1'b1) begin
            err_timeout <= 1'b1;
          end
          if (bus.mem_resp) begin
            state       <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  // responses are combinational so the owner sees completion in the mem_resp cycle
  assign bus.i_resp    = bus.mem_resp & (state == SERVE_I);
  assign bus.d_resp    = bus.mem_resp & (state == SERVE_D);
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
module tb_cacheline_arbiter;
  localparam int LINE_W  = 256;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 1024;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit                is_d;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  logic err_timeout;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   stim_done = 1'b0;
  bit   last_d = 1'b1;
  txn_t exp_q[$];

  cacheline_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Memory-side monitor/responder: pops the expected transaction whenever the
  // DUT raises a strobe, checks it stays stable, answers and checks routing.
  task automatic mem_side();
    txn_t t;
    logic [LINE_W-1:0] rd;
    int dly;
    while (!stim_done) begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 1'b1, 1'b0);
        end else begin
          t = exp_q.pop_front();
          chk("grant_write", bus.mem_write, t.wr);
          chk("grant_read", bus.mem_read, !t.wr);
          chk("grant_addr", bus.mem_addr, t.addr);
          if (t.wr) chk("grant_wdata", bus.mem_wdata, t.wdata);
          dly = $urandom_range(0, 4);
          repeat (dly) begin
            @(negedge clk);
            chk("hold_strobe", {bus.mem_read, bus.mem_write}, {!t.wr, t.wr});
            chk("hold_addr", bus.mem_addr, t.addr);
            if (t.wr) chk("hold_wdata", bus.mem_wdata, t.wdata);
          end
          rd = rand_line();
          bus.mem_rdata = rd;
          bus.mem_resp  = 1'b1;
          #1;
          chk("i_resp", bus.i_resp, !t.is_d);
          chk("d_resp", bus.d_resp, t.is_d);
          if (t.is_d) chk("d_rdata", bus.d_rdata, rd);
          else        chk("i_rdata", bus.i_rdata, rd);
          @(negedge clk);
          bus.mem_resp = 1'b0;
          chk("turnaround_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
        end
      end
    end
  endtask

  task automatic driver();
    int  pat, dop, guard;
    bit  i_pend, d_pend, d_wr, d_first;
    logic [ADDR_W-1:0] ia, da;
    logic [LINE_W-1:0] dw;
    txn_t ti, td;
    for (int r = 0; r < 150; r++) begin
      pat = $urandom_range(0, 2);          // 0: I only, 1: D only, 2: tie
      dop = $urandom_range(0, 2);          // 0: read, 1: write, 2: read+write
      i_pend = (pat != 1);
      d_pend = (pat != 0);
      d_wr   = (dop != 0);
      ia = $urandom; da = $urandom; dw = rand_line();
      ti = '{is_d: 1'b0, wr: 1'b0, addr: ia, wdata: '0};
      td = '{is_d: 1'b1, wr: d_wr, addr: da, wdata: dw};
      if (i_pend && d_pend) begin
        d_first = !(RR && last_d);
        if (d_first) begin exp_q.push_back(td); exp_q.push_back(ti); last_d = 1'b0; end
        else         begin exp_q.push_back(ti); exp_q.push_back(td); last_d = 1'b1; end
      end else if (i_pend) begin
        exp_q.push_back(ti); last_d = 1'b0;
      end else begin
        exp_q.push_back(td); last_d = 1'b1;
      end
      bus.i_read  = i_pend;
      bus.i_addr  = ia;
      bus.d_read  = d_pend && (dop != 1);
      bus.d_write = d_pend && (dop != 0);
      bus.d_addr  = da;
      bus.d_wdata = dw;
      guard = 0;
      while ((i_pend || d_pend) && guard < 300) begin
        @(negedge clk);
        #2;
        if (bus.i_resp) begin i_pend = 1'b0; bus.i_read = 1'b0; end
        if (bus.d_resp) begin d_pend = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; end
        // upstream data changes during service must not reach the memory port
        if (bus.mem_write && d_pend) bus.d_wdata = rand_line();
        guard++;
      end
      if (guard >= 300) chk("response_timeout", 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    stim_done = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
    chk("rst_addr", bus.mem_addr, '0);
    chk("rst_wdata", bus.mem_wdata, '0);
    chk("rst_resp", {bus.i_resp, bus.d_resp, err_timeout}, 3'b000);
    @(negedge clk); rst = 1'b0;

    // I-cache fill with one-cycle grant latency
    @(posedge clk); #1;
    bus.i_read = 1'b1; bus.i_addr = 32'h4000_0020;
    @(negedge clk);
    chk("latency_pre", bus.mem_read, 1'b0);
    @(negedge clk);
    chk("i_fill_read", {bus.mem_read, bus.mem_write}, 2'b10);
    chk("i_fill_addr", bus.mem_addr, 32'h4000_0020);
    bus.mem_rdata = {8{32'hA5A5_A5A5}}; bus.mem_resp = 1'b1;
    #1;
    chk("i_fill_resp", {bus.i_resp, bus.d_resp}, 2'b10);
    chk("i_fill_rdata", bus.i_rdata, {8{32'hA5A5_A5A5}});
    bus.i_read = 1'b0;
    @(negedge clk); bus.mem_resp = 1'b0;
    chk("i_fill_done", bus.mem_read, 1'b0);

    // spurious response while idle
    @(negedge clk); bus.mem_resp = 1'b1;
    #1;
    chk("spurious_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    @(negedge clk); bus.mem_resp = 1'b0;
    chk("spurious_state", {bus.mem_read, bus.mem_write}, 2'b00);

    // timeout: response withheld well past TIMEOUT cycles
    @(posedge clk); #1;
    bus.d_read = 1'b1; bus.d_addr = 32'h1000_0040;
    @(negedge clk); @(negedge clk);
    chk("to_grant", {bus.mem_read, bus.mem_write}, 2'b10);
    bus.d_read = 1'b0;
    repeat (TIMEOUT - 24) @(negedge clk);
    chk("to_before", {bus.mem_read, err_timeout}, 2'b10);
    repeat (40) @(negedge clk);
    chk("to_after", {bus.mem_read, err_timeout}, 2'b11);
    bus.mem_resp = 1'b1;
    #1;
    chk("to_d_resp", {bus.i_resp, bus.d_resp}, 2'b01);
    @(negedge clk); bus.mem_resp = 1'b0;
    chk("to_sticky", err_timeout, 1'b1);

    // reset in the middle of a D writeback
    @(posedge clk); #1;
    bus.d_write = 1'b1; bus.d_addr = 32'h1000_0040; bus.d_wdata = {16{16'h1234}};
    @(negedge clk); @(negedge clk);
    chk("wb_write", {bus.mem_read, bus.mem_write}, 2'b01);
    chk("wb_wdata", bus.mem_wdata, {16{16'h1234}});
    rst = 1'b1; bus.d_write = 1'b0;
    #1;
    chk("rst_mid_serve", {bus.mem_read, bus.mem_write, err_timeout}, 3'b000);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", {bus.mem_read, bus.mem_write}, 2'b00);
    last_d = 1'b1;

    fork
      driver();
      mem_side();
    join
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
